// File: rtl/fir_sink_pkg.sv
// Shared types and the round/saturate helper for the FirFilter output sink.
// The helper works on a fixed maximum width so callers can pass their own widths.
package fir_sink_pkg;

  localparam int MAX_W = 32;

  typedef struct packed {
    logic signed [MAX_W-1:0] data;
    logic                    sat;
  } sink_entry_t;

  // Round half-up by dropping (in_w - out_w) LSBs, then clamp to out_w signed.
  function automatic sink_entry_t round_sat(input logic signed [MAX_W-1:0] din,
                                            input int in_w,
                                            input int out_w);
    sink_entry_t r;
    longint      t;
    longint      hi;
    longint      lo;
    int          s;
    r.data = din;
    r.sat  = 1'b0;
    s      = in_w - out_w;
    if (s > 0) begin
      t  = (longint'(din) + (longint'(1) <<< (s - 1))) >>> s;
      hi = (longint'(1) <<< (out_w - 1)) - 1;
      lo = -(longint'(1) <<< (out_w - 1));
      if (t > hi) begin
        t     = hi;
        r.sat = 1'b1;
      end else if (t < lo) begin
        t     = lo;
        r.sat = 1'b1;
      end
      r.data = t[MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers and a
// registered occupancy count. A write while full is accepted only if a read fires.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_fire;
  logic             rd_fire;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);

  // The head is forced to zero when empty so the output is clean after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_sink.sv
// Receive side of the FirFilter stream: decimate, round/saturate, buffer,
// and present the words on a ready/valid port with a sticky overflow flag.
module fir_out_sink
  import fir_sink_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 12,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [IN_WIDTH-1:0]           din,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [OUT_WIDTH-1:0]          m_data,
  output logic                          m_sat,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int ENTRY_W = OUT_WIDTH + 1;

  logic [PHASE_W-1:0]      phase;
  logic                    keep;
  logic signed [MAX_W-1:0] din_ext;
  sink_entry_t             rs;
  logic                    s1_valid;
  logic [OUT_WIDTH-1:0]    s1_data;
  logic                    s1_sat;
  logic [ENTRY_W-1:0]      head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    ovf_set;

  assign keep = valid_in && (phase == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (valid_in) begin
      phase <= (phase == PHASE_W'(DECIM - 1)) ? '0 : phase + 1'b1;
    end
  end

  assign din_ext = MAX_W'($signed(din));

  always_comb begin
    rs = round_sat(din_ext, IN_WIDTH, OUT_WIDTH);
  end

  generate
    if (OUT_WIDTH < MAX_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^rs.data[MAX_W-1:OUT_WIDTH];
    end
  endgenerate

  // Stage 1: a reset drops whatever word is in flight here.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_data <= rs.data[OUT_WIDTH-1:0];
        s1_sat  <= rs.sat;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s1_valid),
    .wr_data ({s1_sat, s1_data}),
    .rd_en   (m_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = head[OUT_WIDTH-1:0];
  assign m_sat   = head[OUT_WIDTH];

  // A drop only happens when full and no read frees a slot in the same cycle.
  assign ovf_set = s1_valid && fifo_full && !(m_valid && m_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_out_sink.sv
// Self-checking bench: two sinks (DECIM=1 and DECIM=4) share one stimulus stream
// and are compared every cycle against a queue-based model of the sink behaviour.
module tb_fir_out_sink;

  localparam int IN_W  = 16;
  localparam int OUT_W = 12;
  localparam int DEPTH = 8;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             sat;
  } tb_entry_t;

  logic             clk;
  logic             rst;
  logic             valid_in;
  logic [IN_W-1:0]  din;
  logic             m_ready;
  logic             clr_ovf;

  logic             m_valid1, m_sat1, overflow1;
  logic [OUT_W-1:0] m_data1;
  logic [3:0]       level1;
  logic             m_valid4, m_sat4, overflow4;
  logic [OUT_W-1:0] m_data4;
  logic [3:0]       level4;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  tb_entry_t        mq [2][$];
  bit               s1v [2];
  tb_entry_t        s1w [2];
  int               ph [2];
  bit               movf [2];
  int               decim [2] = '{1, 4};
  logic [OUT_W-1:0] log1 [$];
  logic [OUT_W-1:0] log4 [$];

  fir_out_sink #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DECIM(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_sat(m_sat1),
    .level(level1), .overflow(overflow1), .clr_ovf(clr_ovf)
  );

  fir_out_sink #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DECIM(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_sat(m_sat4),
    .level(level4), .overflow(overflow4), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round half-up to OUT_W bits then clamp, straight from the arithmetic definition.
  function automatic tb_entry_t model_word(input logic [IN_W-1:0] d);
    tb_entry_t e;
    longint    v;
    longint    t;
    longint    hi;
    longint    lo;
    int        s;
    s  = IN_W - OUT_W;
    v  = longint'($signed(d));
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (s == 0) t = v;
    else        t = (v + (longint'(1) << (s - 1))) >>> s;
    e.sat = (t > hi) || (t < lo);
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    e.data = t[OUT_W-1:0];
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d);
    valid_in = v;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Model update: inputs are stable at the edge, outputs are checked at the negedge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit rd;
      bit set;
      int sz;
      if (rst) begin
        mq[i].delete();
        s1v[i]  = 1'b0;
        ph[i]   = 0;
        movf[i] = 1'b0;
      end else begin
        sz  = mq[i].size();
        rd  = (sz > 0) && m_ready;
        set = 1'b0;
        if (rd) void'(mq[i].pop_front());
        if (s1v[i]) begin
          if (sz < DEPTH || rd) mq[i].push_back(s1w[i]);
          else                  set = 1'b1;
        end
        if (set)          movf[i] = 1'b1;
        else if (clr_ovf) movf[i] = 1'b0;
        s1v[i] = valid_in && (ph[i] == 0);
        if (s1v[i]) s1w[i] = model_word(din);
        if (valid_in) ph[i] = (ph[i] + 1) % decim[i];
      end
    end
  end

  task automatic compareDut(input int i, input logic mv, input logic [OUT_W-1:0] md,
                            input logic ms, input logic [3:0] lv, input logic ov);
    string tag;
    tag = $sformatf("d%0d", decim[i]);
    checkOutput({tag, "_level"}, lv, mq[i].size());
    checkOutput({tag, "_m_valid"}, mv, mq[i].size() > 0);
    checkOutput({tag, "_overflow"}, ov, movf[i]);
    if (mq[i].size() > 0 && mv) begin
      checkOutput({tag, "_m_data"}, md, mq[i][0].data);
      checkOutput({tag, "_m_sat"}, ms, mq[i][0].sat);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      compareDut(0, m_valid1, m_data1, m_sat1, level1, overflow1);
      compareDut(1, m_valid4, m_data4, m_sat4, level4, overflow4);
      if (m_valid1 && m_ready) log1.push_back(m_data1);
      if (m_valid4 && m_ready) log4.push_back(m_data4);
    end
  end

  initial begin
    logic [IN_W-1:0]  rv_din  [5] = '{16'h0018, 16'hFFE8, 16'h0007, 16'h7FF8, 16'h8000};
    logic [OUT_W-1:0] rv_data [5] = '{12'h002, 12'hFFF, 12'h000, 12'h7FF, 12'h800};
    logic             rv_sat  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [IN_W-1:0]  edge_din [4] = '{16'h7FFF, 16'h8000, 16'h7FF8, 16'h7FF7};
    logic [OUT_W-1:0] exp_dec [3] = '{12'h000, 12'h004, 12'h008};
    int               ready_pct;
    int               guard;

    rst = 1'b1; valid_in = 1'b0; din = '0; m_ready = 1'b1; clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    check_en = 1;
    checkOutput("reset_m_valid", m_valid1, 0);
    checkOutput("reset_m_data", m_data1, 0);
    checkOutput("reset_m_sat", m_sat1, 0);
    checkOutput("reset_level", level1, 0);
    checkOutput("reset_overflow", overflow1, 0);
    rst = 1'b0;

    // Rounding and saturation on the DECIM=1 sink, including the 2-cycle latency.
    for (int k = 0; k < 5; k++) begin
      resetDut();
      applyStimulus(1'b1, rv_din[k]);
      checkOutput("latency_not_early", m_valid1, 0);
      applyStimulus(1'b0, '0);
      checkOutput("latency_valid", m_valid1, 1);
      checkOutput($sformatf("round_data_%0h", rv_din[k]), m_data1, rv_data[k]);
      checkOutput($sformatf("round_sat_%0h", rv_din[k]), m_sat1, rv_sat[k]);
      applyStimulus(1'b0, '0);
    end

    // Decimation by 4 with an idle gap that must not advance the phase.
    resetDut();
    log4.delete();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 16'(16 * k));
      if (k == 5) repeat (3) applyStimulus(1'b0, '0);
    end
    repeat (4) applyStimulus(1'b0, '0);
    checkOutput("decim_count", log4.size(), 3);
    for (int k = 0; k < 3 && k < log4.size(); k++)
      checkOutput($sformatf("decim_word%0d", k), log4[k], exp_dec[k]);

    // Backpressure until the FIFO overflows, then drain and clear.
    resetDut();
    m_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 16'(16 * k));
      if (k == 9) begin
        checkOutput("bp_level_full", level1, 8);
        checkOutput("bp_no_ovf_yet", overflow1, 0);
      end
      if (k == 10) checkOutput("bp_ovf_set", overflow1, 1);
    end
    applyStimulus(1'b0, '0);
    checkOutput("bp_level_after", level1, 8);
    checkOutput("bp_ovf_after", overflow1, 1);
    log1.delete();
    m_ready = 1'b1;
    guard = 0;
    while (level1 != 0 && guard < 20) begin
      applyStimulus(1'b0, '0);
      guard++;
    end
    checkOutput("drain_level", level1, 0);
    checkOutput("drain_count", log1.size(), 8);
    for (int k = 0; k < 8 && k < log1.size(); k++)
      checkOutput($sformatf("drain_word%0d", k), log1[k], k + 1);
    clr_ovf = 1'b1;
    applyStimulus(1'b0, '0);
    clr_ovf = 1'b0;
    checkOutput("clr_ovf", overflow1, 0);

    // Full FIFO with a read and a write on every edge keeps the level at 8.
    resetDut();
    m_ready = 1'b0;
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 16'(16 * k));
    repeat (2) applyStimulus(1'b0, '0);
    checkOutput("full_fill", level1, 8);
    applyStimulus(1'b1, 16'h0100);
    m_ready = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(1'b1, 16'(16'h0100 + 16 * k));
      checkOutput("full_stream_level", level1, 8);
    end
    checkOutput("full_stream_ovf", overflow1, 0);
    repeat (12) applyStimulus(1'b0, '0);

    // Reset while stage 1 holds a kept word and the DECIM=4 FIFO holds 3 words.
    resetDut();
    m_ready = 1'b0;
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, 16'(16 * k));
    applyStimulus(1'b1, 16'h0300);
    checkOutput("mid_level3", level4, 3);
    rst = 1'b1;
    applyStimulus(1'b0, '0);
    rst = 1'b0;
    checkOutput("mid_rst_valid", m_valid4, 0);
    checkOutput("mid_rst_level", level4, 0);
    m_ready = 1'b1;
    log4.delete();
    applyStimulus(1'b1, 16'h0500);
    repeat (3) applyStimulus(1'b1, 16'h0510);
    repeat (4) applyStimulus(1'b0, '0);
    checkOutput("mid_post_count", log4.size(), 1);
    if (log4.size() > 0) checkOutput("mid_post_first", log4[0], 12'h050);

    // Randomized traffic with varying backpressure and occasional overflow clears.
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ready_pct = $urandom_range(10, 100);
      m_ready = ($urandom_range(1, 100) <= ready_pct);
      clr_ovf = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) applyStimulus($urandom_range(0, 2) != 0, edge_din[$urandom_range(0, 3)]);
      else                           applyStimulus($urandom_range(0, 2) != 0, 16'($urandom));
    end
    clr_ovf = 1'b0;
    m_ready = 1'b1;
    repeat (12) applyStimulus(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
